p2s_serializer: RTL and testbench

//   Parallel-in, serial-out transmitter. Captures a DATA_W-bit word on a valid/ready

---
 rtl/p2s_pkg.sv | 15 +
 rtl/p2s_serializer.sv | 96 +++++++++
 tb/tb_p2s_serializer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/p2s_pkg.sv
// Shared types and parameter checks for the parallel-to-serial transmitter.
package p2s_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } p2s_state_t;

    localparam int P2S_MIN_DATA_W = 2;

    function automatic bit p2s_width_ok(input int data_w);
        return data_w >= P2S_MIN_DATA_W;
    endfunction

endpackage

// File: rtl/p2s_serializer.sv
// Parallel-in, serial-out transmitter: captures a word on valid/ready and shifts it
// out one bit per clk with registered sdata_o/svalid_o/last_o framing.
module p2s_serializer
    import p2s_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic              sdata_o,
    output logic              svalid_o,
    output logic              last_o,
    output logic              busy_o
);

    localparam bit               WIDTH_OK = p2s_width_ok(DATA_W);
    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    if (!WIDTH_OK) begin : g_bad_width
        $error("p2s_serializer: DATA_W must be at least %0d", P2S_MIN_DATA_W);
    end

    p2s_state_t        state_q, state_d;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shifted;
    logic [CNT_W-1:0]  cnt_q;
    logic              accept;
    logic              at_last;

    // The bit on the wire is always the head of shift_q, so the next bit is the
    // head of the shifted word.
    function automatic logic head_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    assign shifted = advance(shift_q);
    assign at_last = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    assign ready_o = ~reset & ((state_q == IDLE) | last_o);
    assign accept  = valid_i & ready_o;
    assign busy_o  = (state_q == SHIFT);

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (at_last && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q  <= '0;
            cnt_q    <= '0;
            sdata_o  <= 1'b0;
            svalid_o <= 1'b0;
            last_o   <= 1'b0;
        end else if (accept) begin
            shift_q  <= data_i;
            cnt_q    <= '0;
            sdata_o  <= head_bit(data_i);
            svalid_o <= 1'b1;
            last_o   <= 1'b0;
        end else if ((state_q == SHIFT) && !at_last) begin
            shift_q  <= shifted;
            cnt_q    <= cnt_q + 1'b1;
            sdata_o  <= head_bit(shifted);
            svalid_o <= 1'b1;
            last_o   <= (cnt_q == CNT_LAST - 1'b1);
        end else begin
            // Idle, or final bit sent with no follow-on word.
            shift_q  <= '0;
            cnt_q    <= '0;
            sdata_o  <= 1'b0;
            svalid_o <= 1'b0;
            last_o   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_p2s_serializer.sv
// Self-checking bench for p2s_serializer: LSB-first, MSB-first and 2-bit instances
// compared cycle by cycle against a queue-of-pending-bits reference model.
module tb_p2s_serializer;

    typedef struct packed {
        logic b;
        logic last;
    } ent_t;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       valid8 = 1'b0;
    logic [7:0] data8  = 8'h00;
    logic       valid2 = 1'b0;
    logic [1:0] data2  = 2'b00;

    logic rdy_l, sd_l, sv_l, ls_l, bz_l;
    logic rdy_m, sd_m, sv_m, ls_m, bz_m;
    logic rdy_2, sd_2, sv_2, ls_2, bz_2;
    logic [4:0] obs_l, obs_m, obs_2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Bits still to appear on each 8-bit line, head = bit visible this cycle.
    ent_t q_l[$];
    ent_t q_m[$];

    always #5 clk = ~clk;

    // Observation order: {busy, ready, svalid, sdata, last}
    assign obs_l = {bz_l, rdy_l, sv_l, sd_l, ls_l};
    assign obs_m = {bz_m, rdy_m, sv_m, sd_m, ls_m};
    assign obs_2 = {bz_2, rdy_2, sv_2, sd_2, ls_2};

    p2s_serializer #(.DATA_W(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .valid_i(valid8), .data_i(data8),
        .ready_o(rdy_l), .sdata_o(sd_l), .svalid_o(sv_l), .last_o(ls_l), .busy_o(bz_l)
    );

    p2s_serializer #(.DATA_W(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .valid_i(valid8), .data_i(data8),
        .ready_o(rdy_m), .sdata_o(sd_m), .svalid_o(sv_m), .last_o(ls_m), .busy_o(bz_m)
    );

    p2s_serializer #(.DATA_W(2), .MSB_FIRST(1'b0)) u_w2 (
        .clk(clk), .reset(reset), .valid_i(valid2), .data_i(data2),
        .ready_o(rdy_2), .sdata_o(sd_2), .svalid_o(sv_2), .last_o(ls_2), .busy_o(bz_2)
    );

    function automatic logic [4:0] model_vec(input bit msb);
        ent_t f;
        int   n;
        n = msb ? q_m.size() : q_l.size();
        if (n == 0) return 5'b01000;
        f = msb ? q_m[0] : q_l[0];
        return {1'b1, f.last, 1'b1, f.b, f.last};
    endfunction

    // Drive one cycle on the 8-bit pair (called at a negedge, returns at the next).
    task automatic drive8(input logic v, input logic [7:0] d);
        logic rdy;
        ent_t e;
        rdy    = (q_l.size() == 0) || q_l[0].last;
        valid8 = v;
        data8  = d;
        @(posedge clk);
        if (q_l.size() > 0) begin
            q_l.delete(0);
            q_m.delete(0);
        end
        if (v && rdy) begin
            for (int k = 0; k < 8; k++) begin
                e.b    = d[k];
                e.last = (k == 7);
                q_l.push_back(e);
                e.b    = d[7-k];
                q_m.push_back(e);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({sv_l, sd_l, ls_l, bz_l, sv_m, sd_m, ls_m, bz_m, sv_2, sd_2, ls_2, bz_2} !== 12'h000) begin
            bad++;
            $display("FAIL reset_hold got=%b%b%b%b %b%b%b%b %b%b%b%b required all 0",
                     sv_l, sd_l, ls_l, bz_l, sv_m, sd_m, ls_m, bz_m, sv_2, sd_2, ls_2, bz_2);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (obs_l !== 5'b01000 || obs_m !== 5'b01000 || obs_2 !== 5'b01000) begin
            bad++;
            $display("FAIL reset_release got lsb=%b msb=%b w2=%b required 01000 each",
                     obs_l, obs_m, obs_2);
        end
    endtask

    task automatic test_basic(input logic [7:0] w);
        logic [7:0] rx_l;
        logic [7:0] rx_m;
        int         k;
        rx_l = '0;
        rx_m = '0;
        k    = 0;
        drive8(1'b1, w);
        for (int c = 0; c < 10; c++) begin
            total++;
            if (obs_l !== model_vec(0) || obs_m !== model_vec(1)) begin
                bad++;
                $display("FAIL basic_%h cyc=%0d lsb got=%b need=%b msb got=%b need=%b",
                         w, cyc, obs_l, model_vec(0), obs_m, model_vec(1));
            end
            if (sv_l && k < 8) begin
                rx_l[k]   = sd_l;
                rx_m[7-k] = sd_m;
                k++;
            end
            drive8(1'b0, 8'($urandom));
        end
        total++;
        if (rx_l !== w || rx_m !== w || k != 8) begin
            bad++;
            $display("FAIL word_%h lsb_rx=%h msb_rx=%h bits=%0d required %h x2 with 8 bits",
                     w, rx_l, rx_m, k, w);
        end
    endtask

    task automatic test_back_to_back;
        int run;
        int max_run;
        run     = 0;
        max_run = 0;
        drive8(1'b1, 8'hFF);
        for (int c = 0; c < 20; c++) begin
            total++;
            if (obs_l !== model_vec(0) || obs_m !== model_vec(1)) begin
                bad++;
                $display("FAIL b2b cyc=%0d lsb got=%b need=%b msb got=%b need=%b",
                         cyc, obs_l, model_vec(0), obs_m, model_vec(1));
            end
            run     = sv_l ? run + 1 : 0;
            max_run = (run > max_run) ? run : max_run;
            drive8(c < 8, 8'h00);
        end
        total++;
        if (max_run != 16) begin
            bad++;
            $display("FAIL b2b_contiguous svalid_run=%0d required 16", max_run);
        end
    endtask

    task automatic test_ignore;
        logic v;
        drive8(1'b1, 8'h5A);
        for (int c = 0; c < 12; c++) begin
            total++;
            if (obs_l !== model_vec(0) || obs_m !== model_vec(1)) begin
                bad++;
                $display("FAIL ignore cyc=%0d lsb got=%b need=%b msb got=%b need=%b",
                         cyc, obs_l, model_vec(0), obs_m, model_vec(1));
            end
            v = (c >= 2 && c <= 6);
            drive8(v, v ? 8'h3C : 8'h00);
        end
    endtask

    task automatic test_random;
        for (int c = 0; c < 300; c++) begin
            total++;
            if (obs_l !== model_vec(0) || obs_m !== model_vec(1)) begin
                bad++;
                $display("FAIL random cyc=%0d lsb got=%b need=%b msb got=%b need=%b",
                         cyc, obs_l, model_vec(0), obs_m, model_vec(1));
            end
            drive8((c < 290) && ($urandom_range(0, 2) != 0), 8'($urandom));
        end
    endtask

    task automatic test_reset_mid;
        drive8(1'b1, 8'hF0);
        for (int c = 0; c < 3; c++) begin
            total++;
            if (obs_l !== model_vec(0) || obs_m !== model_vec(1)) begin
                bad++;
                $display("FAIL pre_reset cyc=%0d lsb got=%b need=%b msb got=%b need=%b",
                         cyc, obs_l, model_vec(0), obs_m, model_vec(1));
            end
            if (c < 2) drive8(1'b0, 8'h00);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({sv_l, sd_l, ls_l, bz_l, sv_m, sd_m, ls_m, bz_m} !== 8'h00) begin
            bad++;
            $display("FAIL async_reset got=%b%b%b%b %b%b%b%b required all 0 before clk",
                     sv_l, sd_l, ls_l, bz_l, sv_m, sd_m, ls_m, bz_m);
        end
        q_l.delete();
        q_m.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (obs_l !== 5'b01000 || obs_m !== 5'b01000) begin
            bad++;
            $display("FAIL post_reset_idle lsb got=%b msb got=%b required 01000", obs_l, obs_m);
        end
        test_basic(8'h81);
    endtask

    task automatic test_w2;
        logic [1:0] w[4];
        valid2 = 1'b1;
        data2  = 2'b10;
        @(negedge clk);
        valid2 = 1'b0;
        data2  = 2'b00;
        total++;
        if (obs_2 !== 5'b10100) begin
            bad++;
            $display("FAIL w2_bit0 got=%b required 10100", obs_2);
        end
        @(negedge clk);
        total++;
        if (obs_2 !== 5'b11111) begin
            bad++;
            $display("FAIL w2_bit1 got=%b required 11111", obs_2);
        end
        @(negedge clk);
        total++;
        if (obs_2 !== 5'b01000) begin
            bad++;
            $display("FAIL w2_idle got=%b required 01000", obs_2);
        end
        for (int i = 0; i < 4; i++) w[i] = 2'($urandom);
        valid2 = 1'b1;
        data2  = w[0];
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (obs_2 !== {3'b101, w[i][0], 1'b0}) begin
                bad++;
                $display("FAIL w2_b2b_first i=%0d got=%b required %b", i, obs_2, {3'b101, w[i][0], 1'b0});
            end
            valid2 = (i < 3);
            data2  = (i < 3) ? w[(i+1)%4] : 2'b00;
            @(negedge clk);
            total++;
            if (obs_2 !== {3'b111, w[i][1], 1'b1}) begin
                bad++;
                $display("FAIL w2_b2b_last i=%0d got=%b required %b", i, obs_2, {3'b111, w[i][1], 1'b1});
            end
        end
        @(negedge clk);
        total++;
        if (obs_2 !== 5'b01000) begin
            bad++;
            $display("FAIL w2_final_idle got=%b required 01000", obs_2);
        end
    endtask

    initial begin
        test_reset;
        test_basic(8'hA5);
        test_basic(8'h01);
        test_back_to_back;
        test_ignore;
        test_random;
        test_reset_mid;
        test_w2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
